// File: rtl/regfile_writeback.sv
// Write-side driver for the 32x32 register file: buffers write-back requests in a FIFO,
// issues one write per cycle, and runs a drain-then-clear sequence. Optional lookup port: WB_BYPASS_EN.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          Clk,
  input  logic          Rst,
  // Handshake: a request transfers on a rising edge where InValid && InReady.
  // InValid may be raised at any time; InReady never depends on InValid.
  input  logic          InValid,
  output logic          InReady,
  input  logic [4:0]    InRW,
  input  logic [31:0]   InW,
  input  logic          ClrReq,
  output logic          Busy,
  output logic [AW:0]   Pending,
  output logic          RegWr,
  output logic [4:0]    RW,
  output logic [31:0]   BusW,
`ifdef WB_BYPASS_EN
  input  logic [4:0]    LkR,
  output logic          LkHit,
  output logic [31:0]   LkData,
`endif
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic [4:0]  mem_rw [DEPTH];
  logic [31:0] mem_w  [DEPTH];
  logic [4:0]  clr_cnt;
  logic        empty, full, push, pop;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Writes to R0 complete the handshake but never occupy a slot.
  assign push  = InValid && InReady && (InRW != 5'd0);
  assign pop   = (state != CLEAR) && !empty;
  assign Pending = count;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ClrReq) next_state = DRAIN;
      DRAIN:   if (empty) next_state = CLEAR;
      CLEAR:   if (clr_cnt == 5'd31) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    InReady   = Rst && (state == IDLE) && !full;
    Busy      = (state != IDLE);
    dbg_state = state;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      clr_cnt <= 5'd1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (state == CLEAR) clr_cnt <= clr_cnt + 5'd1;
      else                clr_cnt <= 5'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_rw[wr_ptr[AW-1:0]] <= InRW;
      mem_w[wr_ptr[AW-1:0]]  <= InW;
    end
  end

  // RW/BusW hold their last value when nothing issues.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      RegWr <= 1'b0;
      RW    <= 5'd0;
      BusW  <= 32'd0;
    end else if (state == CLEAR) begin
      RegWr <= 1'b1;
      RW    <= clr_cnt;
      BusW  <= 32'd0;
    end else if (pop) begin
      RegWr <= 1'b1;
      RW    <= mem_rw[rd_ptr[AW-1:0]];
      BusW  <= mem_w[rd_ptr[AW-1:0]];
    end else begin
      RegWr <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  logic [AW-1:0] lk_idx;

  // Scan oldest to youngest so the last match wins; the issuing write is older than any entry.
  always_comb begin
    LkHit  = 1'b0;
    LkData = 32'd0;
    lk_idx = rd_ptr[AW-1:0];
    if (LkR != 5'd0) begin
      if (state == CLEAR) begin
        LkHit = 1'b1;
      end else begin
        if (RegWr && (RW == LkR)) begin
          LkHit  = 1'b1;
          LkData = BusW;
        end
        for (int i = 0; i < DEPTH; i++) begin
          lk_idx = rd_ptr[AW-1:0] + AW'(i);
          if (((AW+1)'(i) < count) && (mem_rw[lk_idx] == LkR)) begin
            LkHit  = 1'b1;
            LkData = mem_w[lk_idx];
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-based write-order model.
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        InValid = 1'b0;
  logic [4:0]  InRW = 5'd0;
  logic [31:0] InW = 32'd0;
  logic        ClrReq = 1'b0;
  logic        InReady, Busy, RegWr;
  logic [AW:0] Pending;
  logic [4:0]  RW;
  logic [31:0] BusW;
  logic [1:0]  dbg_state;
`ifdef WB_BYPASS_EN
  logic [4:0]  LkR = 5'd0;
  logic        LkHit;
  logic [31:0] LkData;
`endif

  regfile_writeback #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .InRW(InRW), .InW(InW),
    .ClrReq(ClrReq), .Busy(Busy), .Pending(Pending), .RegWr(RegWr), .RW(RW), .BusW(BusW),
`ifdef WB_BYPASS_EN
    .LkR(LkR), .LkHit(LkHit), .LkData(LkData),
`endif
    .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit sb_on = 1'b0;

  // Model: exp_q holds every write still owed, in issue order ({rw, data}).
  logic [36:0] exp_q[$];
  int          m_mode = 0;       // 0 idle, 1 draining, 2 clearing
  int          m_fifo_cnt = 0;
  int          m_clr_left = 0;
  logic        m_reg_wr = 1'b0;
  logic [4:0]  m_rw = 5'd0;
  logic [31:0] m_busw = 32'd0;

  function automatic bit model_ready();
    return Rst && (m_mode == 0) && (m_fifo_cnt < DEPTH);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fifo_cnt = 0; m_clr_left = 0;
    exp_q.delete();
    m_reg_wr = 1'b0; m_rw = 5'd0; m_busw = 32'd0;
  endtask

  task automatic model_edge();
    bit rdy, issued;
    int pre_mode;
    logic [36:0] e;
    if (!Rst) return;
    rdy = model_ready();
    pre_mode = m_mode;
    issued = 1'b0;
    e = '0;
    if (pre_mode == 2) begin
      issued = 1'b1; e = exp_q.pop_front(); m_clr_left--;
      if (m_clr_left == 0) m_mode = 0;
    end else if (m_fifo_cnt > 0) begin
      issued = 1'b1; e = exp_q.pop_front(); m_fifo_cnt--;
    end else if (pre_mode == 1) begin
      m_mode = 2; m_clr_left = 31;
      for (int k = 1; k <= 31; k++) exp_q.push_back({5'(k), 32'd0});
    end
    if (pre_mode == 0 && ClrReq) m_mode = 1;
    if (InValid && rdy && InRW != 5'd0) begin
      exp_q.push_back({InRW, InW});
      m_fifo_cnt++;
    end
    m_reg_wr = issued;
    if (issued) begin m_rw = e[36:32]; m_busw = e[31:0]; end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  always @(negedge Clk) begin
    if (sb_on) begin
      checks++;
      if (RegWr !== m_reg_wr) begin errors++; $display("FAIL sb_regwr t=%0t got %0b expected %0b", $time, RegWr, m_reg_wr); end
      checks++;
      if (RW !== m_rw) begin errors++; $display("FAIL sb_rw t=%0t got %0d expected %0d", $time, RW, m_rw); end
      checks++;
      if (BusW !== m_busw) begin errors++; $display("FAIL sb_busw t=%0t got %h expected %h", $time, BusW, m_busw); end
      checks++;
      if (Pending !== (AW+1)'(m_fifo_cnt)) begin errors++; $display("FAIL sb_pending t=%0t got %0d expected %0d", $time, Pending, m_fifo_cnt); end
      checks++;
      if (Busy !== (m_mode != 0)) begin errors++; $display("FAIL sb_busy t=%0t got %0b expected %0b", $time, Busy, (m_mode != 0)); end
      checks++;
      if (InReady !== model_ready()) begin errors++; $display("FAIL sb_inready t=%0t got %0b expected %0b", $time, InReady, model_ready()); end
    end
  end

  task automatic test_reset();
    #2 Rst = 1'b0;
    model_reset();
    #10;
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL rst_regwr got %0b expected 0", RegWr); end
    checks++; if (RW !== 5'd0) begin errors++; $display("FAIL rst_rw got %0d expected 0", RW); end
    checks++; if (BusW !== 32'd0) begin errors++; $display("FAIL rst_busw got %h expected 0", BusW); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b expected 0", Busy); end
    checks++; if (Pending !== '0) begin errors++; $display("FAIL rst_pending got %0d expected 0", Pending); end
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL rst_inready_low got %0b expected 0", InReady); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d expected 0", dbg_state); end
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL rst_inready_rel got %0b expected 1", InReady); end
    tick();
  endtask

  task automatic test_single();
    InValid = 1'b1; InRW = 5'd5; InW = 32'hDEADBEEF;
    tick();
    InValid = 1'b0;
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL single_k got %0b expected 0", RegWr); end
    checks++; if (Pending !== 3'd1) begin errors++; $display("FAIL single_pend1 got %0d expected 1", Pending); end
    tick();
    checks++; if (RegWr !== 1'b1 || RW !== 5'd5 || BusW !== 32'hDEADBEEF)
      begin errors++; $display("FAIL single_write got %0b/%0d/%h expected 1/5/deadbeef", RegWr, RW, BusW); end
    checks++; if (Pending !== 3'd0) begin errors++; $display("FAIL single_pend0 got %0d expected 0", Pending); end
    tick();
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL single_end got %0b expected 0", RegWr); end
  endtask

  task automatic test_r0_filter();
    logic [4:0]  rws [4] = '{5'd0, 5'd3, 5'd0, 5'd7};
    logic [4:0]  seen_rw[$];
    logic [31:0] seen_w[$];
    for (int i = 0; i < 8; i++) begin
      InValid = (i < 4);
      InRW = (i < 4) ? rws[i] : 5'd0;
      InW = 32'(i + 1);
      tick();
      if (RegWr) begin seen_rw.push_back(RW); seen_w.push_back(BusW); end
    end
    InValid = 1'b0;
    checks++;
    if (seen_rw.size() != 2) begin
      errors++; $display("FAIL r0_pulses got %0d expected 2", seen_rw.size());
    end else if (seen_rw[0] !== 5'd3 || seen_w[0] !== 32'd2 || seen_rw[1] !== 5'd7 || seen_w[1] !== 32'd4) begin
      errors++; $display("FAIL r0_order got %0d/%0d,%0d/%0d expected 3/2,7/4", seen_rw[0], seen_w[0], seen_rw[1], seen_w[1]);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0, pulses = 0, max_pend = 0;
    for (int i = 0; i < 12; i++) begin
      InValid = (i < 8);
      InRW = 5'($urandom_range(1, 31));
      InW = $urandom;
      if (InValid && model_ready()) accepted++;
      tick();
      if (RegWr) pulses++;
      if (int'(Pending) > max_pend) max_pend = int'(Pending);
    end
    InValid = 1'b0;
    checks++; if (pulses != accepted) begin errors++; $display("FAIL bp_count got %0d expected %0d", pulses, accepted); end
    checks++; if (max_pend > DEPTH) begin errors++; $display("FAIL bp_maxpend got %0d expected <=%0d", max_pend, DEPTH); end
  endtask

  task automatic test_clear();
    logic [36:0] seen[$];
    bit done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      InValid = 1'b1; InRW = 5'($urandom_range(1, 31)); InW = $urandom; ClrReq = (i == 2);
      tick();
      if (RegWr) seen.push_back({RW, BusW});
    end
    InValid = 1'b0; ClrReq = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      ClrReq = (c == 15);
      tick();
      ClrReq = 1'b0;
      if (RegWr) seen.push_back({RW, BusW});
      if (Busy) begin
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL clr_inready c=%0d got %0b expected 0", c, InReady); end
      end else done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL clr_timeout got busy expected idle"); end
    checks++;
    if (seen.size() != 34) begin
      errors++; $display("FAIL clr_pulses got %0d expected 34", seen.size());
    end else begin
      for (int j = 0; j < 31; j++)
        if (seen[3+j] !== {5'(j + 1), 32'd0}) begin
          errors++; $display("FAIL clr_seq j=%0d got %h expected rw %0d data 0", j, seen[3+j], j + 1); break;
        end
    end
    tick();
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL clr_after got %0b expected 0", RegWr); end
  endtask

  task automatic test_reset_mid_clear();
    bit hit = 1'b0;
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      tick();
      if (RegWr === 1'b1 && RW === 5'd10) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rmc_reach got none expected rw=10 write"); end
    #2 Rst = 1'b0;
    model_reset();
    #1;
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL rmc_regwr got %0b expected 0", RegWr); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rmc_busy got %0b expected 0", Busy); end
    checks++; if (Pending !== '0) begin errors++; $display("FAIL rmc_pending got %0d expected 0", Pending); end
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL rmc_inready got %0b expected 1", InReady); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rmc_state got %0d expected 0", dbg_state); end
    tick();
  endtask

  task automatic test_random();
    bit settled = 1'b0;
    for (int i = 0; i < 300; i++) begin
      InValid = 1'($urandom_range(0, 1));
      InRW = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      InW = $urandom;
      ClrReq = ($urandom_range(0, 60) == 0);
      tick();
    end
    InValid = 1'b0; ClrReq = 1'b0;
    for (int c = 0; c < 100 && !settled; c++) begin
      tick();
      if (!Busy && Pending == '0 && !RegWr) settled = 1'b1;
    end
    checks++; if (!settled) begin errors++; $display("FAIL rand_settle got busy=%0b pending=%0d expected idle", Busy, Pending); end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    bit done = 1'b0;
    InValid = 1'b1; InRW = 5'd9; InW = 32'h11;
    tick();
    InW = 32'h22;
    tick();
    InValid = 1'b0;
    LkR = 5'd9; #1;
    checks++; if (LkHit !== 1'b1 || LkData !== 32'h22) begin errors++; $display("FAIL byp_young got %0b/%h expected 1/22", LkHit, LkData); end
    LkR = 5'd0; #1;
    checks++; if (LkHit !== 1'b0) begin errors++; $display("FAIL byp_r0 got %0b expected 0", LkHit); end
    LkR = 5'd9;
    tick();
    checks++; if (LkHit !== 1'b1 || LkData !== 32'h22) begin errors++; $display("FAIL byp_issue got %0b/%h expected 1/22", LkHit, LkData); end
    tick();
    checks++; if (LkHit !== 1'b0) begin errors++; $display("FAIL byp_gone got %0b expected 0", LkHit); end
    ClrReq = 1'b1;
    tick();
    ClrReq = 1'b0;
    tick();
    LkR = 5'd17; #1;
    checks++; if (LkHit !== 1'b1 || LkData !== 32'd0) begin errors++; $display("FAIL byp_clear got %0b/%h expected 1/0", LkHit, LkData); end
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (!Busy) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL byp_timeout got busy expected idle"); end
    tick();
    LkR = 5'd0;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    sb_on = 1'b1;
    test_single();
    test_r0_filter();
    test_backpressure();
    test_clear();
    test_reset_mid_clear();
    test_random();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    sb_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side driver for the 32x32 RegisterFile; owns its BusW/RW/RegWr inputs.
- Accepts write-back requests from the datapath via a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one register write per cycle; drops writes to R0.
- Provides a bulk-clear sequence that zeroes R1..R31 after draining pending writes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- InValid  input  1  write-back request valid.
- InReady  output  1  block can accept a request this cycle.
- InRW  input  5  destination register of request.
- InW  input  32  data of request.
- ClrReq  input  1  single-cycle pulse; zero R1..R31.
- Busy  output  1  drain/clear sequence in progress.
- Pending  output  AW+1  number of entries held in FIFO.
- RegWr  output  1  write enable to RegisterFile.
- RW  output  5  write address to RegisterFile.
- BusW  output  32  write data to RegisterFile.

Behaviour:
- Reset (Rst=0, asynchronous):
  - FIFO empty; state IDLE.
  - RegWr=0, RW=0, BusW=0, Busy=0, Pending=0.
  - InReady=0 while Rst is low.
- Handshake: transfer occurs when InValid && InReady at a rising edge. InReady = (state==IDLE) && (Pending<DEPTH), combinational.
- R0 filter: a transfer with InRW==0 completes the handshake but is not stored; Pending is unchanged.
- Issue:
  - In IDLE or DRAIN with FIFO non-empty, each edge pops the head and registers RegWr=1, RW/BusW=head.
  - With FIFO empty, each edge registers RegWr=0; RW/BusW hold their last values.
- Latency and ordering:
  - Request accepted at edge k into an empty FIFO: RegWr=1 after edge k+1; RegisterFile captures at edge k+2.
  - Writes issue in strict acceptance order.
- Simultaneous push and pop on the same edge: both happen; Pending unchanged.
- Full: InReady=0, no push. A pop frees a slot; InReady rises the following cycle.
- State machine, IDLE/DRAIN/CLEAR:
  - IDLE: ClrReq=1 moves to DRAIN at the next edge. A request transferred on that same edge is stored and drained first.
  - DRAIN: InReady=0, Busy=1. Pops continue. Moves to CLEAR on the edge where the FIFO is empty.
  - CLEAR: InReady=0, Busy=1. Counter runs 1..31; each edge registers RegWr=1, RW=counter, BusW=0. After issuing RW=31, returns to IDLE; Busy=0 and RegWr=0 after that edge.
  - ClrReq while Busy=1 is ignored (no queueing).
- Clear duration: exactly 31 consecutive RegWr pulses, no gaps.
- Reset mid-drain or mid-clear: sequence aborted, FIFO contents discarded, outputs return to reset values immediately.
- Pending wraps are impossible: pointers are AW+1 bits wide; full when the pointers differ only in the MSB.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds ports LkR (input 5), LkHit (output 1), LkData (output 32).
  - LkHit=1 when LkR!=0 and LkR matches any pending FIFO entry or the currently issuing RW with RegWr=1.
  - LkData is the youngest matching value, combinational; lets the decode stage bypass the RegisterFile.
  - During CLEAR, LkHit=1 and LkData=0 for any LkR!=0.
- Not defined: ports absent; no lookup logic.

Test Plan:
- Reset then single request InRW=5, InW=0xDEADBEEF at edge k -> RegWr=1, RW=5, BusW=0xDEADBEEF during cycle k+1..k+2 only; Pending returns 0.
- Back-to-back requests with InRW=0, 3, 0, 7 (data 1,2,3,4) -> exactly two write pulses, RW=3/BusW=2 then RW=7/BusW=4; no RW=0 write.
- Backpressure: hold InValid=1 with new data every cycle for 8 cycles -> each accepted request produces exactly one write, in order, with none lost or duplicated; Pending never exceeds 4.
- ClrReq with 3 entries pending -> the 3 entries are written first, then 31 writes RW=1..31 with BusW=0; Busy high throughout; InReady=0 throughout; ClrReq pulsed mid-clear has no effect.
- Rst asserted at the 10th clear write -> RegWr=0, Busy=0, Pending=0 immediately; after release, InReady=1 and the state is IDLE.
- WB_BYPASS_EN: push RW=9 data 0x11, then RW=9 data 0x22 while stalled -> LkR=9 gives LkHit=1, LkData=0x22; LkR=0 gives LkHit=0.
